// File: rtl/hilo_muldiv_pkg.sv
// ============================================================================
//  Module      : hilo_muldiv_pkg
//  Description : Shared op codes, FSM states and default width for hilo_muldiv
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package hilo_muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_muldiv_step.sv
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational shift-add (mul) or restoring-subtract (div) step
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shrem;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}
        w_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: acc = {remainder, quotient}; remainder < divisor so the shift fits WIDTH+1
        w_shrem = acc_i[2*WIDTH-1:WIDTH-1];
        w_diff  = w_shrem[WIDTH-1:0] - opnd_i;
        w_ge    = (w_shrem >= {1'b0, opnd_i});
        if (is_div_i) begin
            acc_o = {(w_ge ? w_diff : w_shrem[WIDTH-1:0]), acc_i[WIDTH-2:0], w_ge};
        end else begin
            acc_o = {w_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// ============================================================================
//  Module      : hilo_muldiv
//  Description : Iterative MIPS multiply/divide unit with HI/LO registers
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     araw_q, araw_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    op_e                  w_op;
    logic                 w_signed;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (w_step)
    );

    always_comb begin
        w_op       = op_e'(op_i);
        w_signed   = (w_op == OP_MULT) || (w_op == OP_DIV);
        w_is_div   = (w_op == OP_DIV)  || (w_op == OP_DIVU);
        w_abs_a    = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        w_abs_b    = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;
        w_prod_fix = neg_res_q ? -acc_q : acc_q;
        w_quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        araw_d    = araw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    case (w_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d   = ST_RUN;
                            cnt_d     = CNT_W'(WIDTH - 1);
                            acc_d     = {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                            opnd_d    = w_is_div ? w_abs_b : w_abs_a;
                            araw_d    = a_i;
                            is_div_d  = w_is_div;
                            neg_res_d = w_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            neg_rem_d = w_signed && a_i[WIDTH-1];
                            divz_d    = w_is_div && (b_i == '0);
                        end
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cancel_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = w_step;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel_i) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = w_prod_fix;
                    end else if (divz_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = w_rem_fix;
                        lo_d = w_quo_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            araw_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            araw_q    <= araw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// ============================================================================
//  Module      : tb_hilo_muldiv
//  Description : Self-checking bench for hilo_muldiv against an arithmetic model
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        cancel_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_errors = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cancel_i (cancel_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, Verilog division truncates toward zero
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        eh = hi_o;
        el = lo_o;
        case (op)
            3'd0: begin p = sa * sb; {eh, el} = p; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at);
        logic [31:0] eh, el, h0, l0;
        int lat, bcnt;
        bit stable;
        model(op, a, b, eh, el);
        h0 = hi_o;
        l0 = lo_o;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0; a_i = $urandom; b_i = $urandom;
        lat = 0; bcnt = 0; stable = 1'b1;
        while (!done_o && lat < 50) begin
            if (busy_o) bcnt++;
            if (hi_o !== h0 || lo_o !== l0) stable = 1'b0;
            start_i = (lat == restart_at);
            if (lat == restart_at) op_i = 3'd1;
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
        chk("latency", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(bcnt), 64'd33);
        chk("hilo_stable", {63'b0, stable}, 64'd1);
        chk("busy_at_done", {63'b0, busy_o}, 64'd0);
        chk("hi", {32'b0, hi_o}, {32'b0, eh});
        chk("lo", {32'b0, lo_o}, {32'b0, el});
        @(negedge clk);
        chk("done_one_cycle", {63'b0, done_o}, 64'd0);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] v);
        logic [31:0] eh, el;
        model(op, v, 32'h0, eh, el);
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = v;
        @(negedge clk);
        start_i = 1'b0;
        chk("mt_hi", {32'b0, hi_o}, {32'b0, eh});
        chk("mt_lo", {32'b0, lo_o}, {32'b0, el});
        chk("mt_busy", {63'b0, busy_o}, 64'd0);
        chk("mt_done", {63'b0, done_o}, 64'd0);
    endtask

    task automatic run_cancel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int at);
        logic [31:0] h0, l0;
        bit seen_done;
        h0 = hi_o; l0 = lo_o; seen_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        repeat (at - 1) @(negedge clk);
        chk("cancel_busy_pre", {63'b0, busy_o}, 64'd1);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        chk("cancel_busy", {63'b0, busy_o}, 64'd0);
        chk("cancel_hi", {32'b0, hi_o}, {32'b0, h0});
        chk("cancel_lo", {32'b0, lo_o}, {32'b0, l0});
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        chk("cancel_no_done", {63'b0, seen_done}, 64'd0);
        chk("cancel_hi_late", {32'b0, hi_o}, {32'b0, h0});
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_hi", {32'b0, hi_o}, 64'd0);
        chk("rst_lo", {32'b0, lo_o}, 64'd0);
        chk("rst_busy", {63'b0, busy_o}, 64'd0);
        chk("rst_done", {63'b0, done_o}, 64'd0);
        rst_n = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("multu_max_hi", {32'b0, hi_o}, 64'h0000_0000_FFFF_FFFE);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1);
        chk("mult_neg_lo", {32'b0, lo_o}, 64'h0000_0000_FFFF_FFEB);
        run_op(3'd3, 32'd7, 32'd2, -1);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_neg_hi", {32'b0, hi_o}, 64'h0000_0000_FFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_ovf_lo", {32'b0, lo_o}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'h1234_5678, 32'd0, -1);
        run_op(3'd3, 32'h1234_5678, 32'd0, -1);
        chk("divz_lo", {32'b0, lo_o}, 64'h0000_0000_FFFF_FFFF);
        run_mt(3'd4, 32'hAAAA_5555);
        run_mt(3'd5, 32'h5A5A_A5A5);
        run_op(3'd1, 32'h0001_0003, 32'h0000_0011, 5);
        run_cancel(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 10);
        run_cancel(3'd2, 32'h8765_4321, 32'h0000_0003, 33);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 5 == 0) rb = 32'd0;
            if (i % 7 == 1) rb = 32'($urandom_range(1, 9));
            if (i % 6 == 2) ra = 32'h8000_0000;
            if (i % 8 == 3) rb = 32'hFFFF_FFFF;
            run_op(rop, ra, rb, (i % 4 == 0) ? int'($urandom_range(0, 31)) : -1);
            if (i % 10 == 9) run_mt(3'($urandom_range(4, 5)), $urandom);
        end

        // Asynchronous reset in the middle of a divide
        run_mt(3'd4, 32'hCAFE_F00D);
        run_mt(3'd5, 32'h0BAD_BEEF);
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd2; a_i = 32'hFFFF_0000; b_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", {32'b0, hi_o}, 64'd0);
        chk("arst_lo", {32'b0, lo_o}, 64'd0);
        chk("arst_busy", {63'b0, busy_o}, 64'd0);
        chk("arst_done", {63'b0, done_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd1, 32'd3, 32'd5, -1);
        chk("post_rst_lo", {32'b0, lo_o}, 64'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
